// File: rtl/clock_div_pkg.sv
// clock_div_pkg: shared widths, default ratios and the ratio helper for the
// programmable clock/tick divider.
`default_nettype none

package clock_div_pkg;

  localparam int CNT_W_DEFAULT = 28;
  localparam longint unsigned SYS_HZ = 64'd100_000_000;

  // Ratio for a target frequency. A zero target returns 0, which the write
  // port rejects.
  function automatic logic [CNT_W_DEFAULT-1:0] div_for_hz(
    input longint unsigned sys_hz,
    input longint unsigned hz
  );
    longint unsigned q;
    q = (hz == 0) ? 64'd0 : sys_hz / hz;
    return q[CNT_W_DEFAULT-1:0];
  endfunction

  localparam logic [CNT_W_DEFAULT-1:0] DIV_1HZ   = div_for_hz(SYS_HZ, 64'd1);
  localparam logic [CNT_W_DEFAULT-1:0] DIV_4HZ   = div_for_hz(SYS_HZ, 64'd4);
  localparam logic [CNT_W_DEFAULT-1:0] DIV_64HZ  = div_for_hz(SYS_HZ, 64'd64);
  localparam logic [CNT_W_DEFAULT-1:0] DIV_500HZ = div_for_hz(SYS_HZ, 64'd500);

endpackage

`default_nettype wire

// File: rtl/clock_div_ch.sv
// clock_div_ch: one divider channel -- counter, shadow ratio with pending
// flag, and registered divided-clock and tick outputs.
`default_nettype none

module clock_div_ch
  import clock_div_pkg::*;
#(
  parameter int               CNT_W   = CNT_W_DEFAULT,
  parameter logic [CNT_W-1:0] DIV_RST = CNT_W'(2)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             sync_clr_i,
  input  logic             wr_i,
  input  logic [CNT_W-1:0] wr_div_i,
  output logic             clk_o,
  output logic             tick_o,
  output logic             pending_o
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_act_q, div_act_d;
  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic             pend_q, pend_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  logic             wrap;
  logic             load;

  always_comb begin
    wrap      = en_i && (cnt_q == div_act_q - ONE);
    load      = !en_i || sync_clr_i || wrap;
    cnt_d     = load ? '0 : cnt_q + ONE;
    div_act_d = div_act_q;
    shadow_d  = wr_i ? wr_div_i : shadow_q;
    pend_d    = pend_q;
    // A write on a load edge goes straight into the active ratio.
    if (load) begin
      if (wr_i) begin
        div_act_d = wr_div_i;
      end else if (pend_q) begin
        div_act_d = shadow_q;
      end
      pend_d = 1'b0;
    end else if (wr_i) begin
      pend_d = 1'b1;
    end
    tick_d = wrap && !sync_clr_i;
    clk_d  = en_i && (cnt_d < (div_act_d >> 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      div_act_q <= DIV_RST;
      shadow_q  <= DIV_RST;
      pend_q    <= 1'b0;
      clk_q     <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      div_act_q <= div_act_d;
      shadow_q  <= shadow_d;
      pend_q    <= pend_d;
      clk_q     <= clk_d;
      tick_q    <= tick_d;
    end
  end

  assign clk_o     = clk_q;
  assign tick_o    = tick_q;
  assign pending_o = pend_q;

endmodule

`default_nettype wire

// File: rtl/clock_div_prog.sv
// clock_div_prog: NUM_CH programmable clock/tick dividers sharing one ratio
// write port and a global phase realign.
`default_nettype none

module clock_div_prog
  import clock_div_pkg::*;
#(
  parameter int                      NUM_CH      = 4,
  parameter int                      CNT_W       = CNT_W_DEFAULT,
  parameter logic [NUM_CH*CNT_W-1:0] DIV_DEFAULT = {DIV_500HZ, DIV_64HZ, DIV_4HZ, DIV_1HZ}
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_CH-1:0]      en,
  input  logic                   sync_clr,
  input  logic                   wr_en,
  // One extra bit so out-of-range channel numbers can be presented and rejected.
  input  logic [$clog2(NUM_CH):0] wr_ch,
  input  logic [CNT_W-1:0]       wr_div,
  output logic [NUM_CH-1:0]      o_clk,
  output logic [NUM_CH-1:0]      o_tick,
  output logic [NUM_CH-1:0]      o_pending,
  output logic                   o_wr_err
);

  localparam int CH_W = $clog2(NUM_CH) + 1;

  logic wr_ok;
  logic err_q;

  assign wr_ok = wr_en && (wr_div != '0) && (wr_ch < CH_W'(NUM_CH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= wr_en && !wr_ok;
    end
  end

  assign o_wr_err = err_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clock_div_ch #(
      .CNT_W   (CNT_W),
      .DIV_RST (DIV_DEFAULT[i*CNT_W +: CNT_W])
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .en_i       (en[i]),
      .sync_clr_i (sync_clr),
      .wr_i       (wr_ok && (wr_ch == CH_W'(i))),
      .wr_div_i   (wr_div),
      .clk_o      (o_clk[i]),
      .tick_o     (o_tick[i]),
      .pending_o  (o_pending[i])
    );
  end

endmodule

`default_nettype wire
